// File: rtl/l1d_tlb_pkg.sv
// Shared types for the L1D TLB slice.
//   - pgsize encodings PG_1G / PG_2M / PG_4K / PG_64K
//   - page_walk_rsp_t : result returned by the page-table walker
//   - tlb_entry_t     : one cached translation
//   - tlb_state_e     : lookup/walk controller states
package l1d_tlb_pkg;

  localparam logic [1:0] PG_1G  = 2'd0;
  localparam logic [1:0] PG_2M  = 2'd1;
  localparam logic [1:0] PG_4K  = 2'd2;
  localparam logic [1:0] PG_64K = 2'd3;

  typedef struct packed {
    logic [63:0] paddr;
    logic        fault;
    logic        dirty;
    logic        readable;
    logic        writable;
    logic        executable;
    logic        user;
    logic        gbl;
    logic [1:0]  pgsize;
  } page_walk_rsp_t;

  typedef struct packed {
    logic        valid;
    logic [26:0] vpn;     // va[38:12]
    logic [1:0]  pgsize;
    logic [43:0] ppn;     // paddr[55:12]
    logic        dirty;
    logic        readable;
    logic        writable;
    logic        executable;
    logic        user;
    logic        gbl;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WALK,
    ST_WAIT
  } tlb_state_e;

endpackage

// File: rtl/l1d_tlb_match.sv
// Combinational compare of one TLB entry against a virtual address.
// Ports:
//   i_entry : cached translation
//   i_va    : lookup virtual address
//   o_hit   : entry valid and tag bits for its page size match
//   o_pa    : formed physical address, forced to zero when not hitting so
//             the top can OR-reduce all entries
module tlb_match
  import l1d_tlb_pkg::*;
(
  input  tlb_entry_t  i_entry,
  input  logic [63:0] i_va,
  output logic        o_hit,
  output logic [63:0] o_pa
);

  logic        w_tag_eq;
  logic [63:0] w_pa;

  always_comb begin
    w_tag_eq = 1'b0;
    w_pa     = '0;
    case (i_entry.pgsize)
      PG_1G: begin
        w_tag_eq = (i_entry.vpn[26:18] == i_va[38:30]);
        w_pa     = {8'd0, i_entry.ppn[43:18], i_va[29:0]};
      end
      PG_2M: begin
        w_tag_eq = (i_entry.vpn[26:9] == i_va[38:21]);
        w_pa     = {8'd0, i_entry.ppn[43:9], i_va[20:0]};
      end
      PG_64K: begin
        w_tag_eq = (i_entry.vpn[26:4] == i_va[38:16]);
        w_pa     = {8'd0, i_entry.ppn[43:4], i_va[15:0]};
      end
      default: begin
        w_tag_eq = (i_entry.vpn == i_va[38:12]);
        w_pa     = {8'd0, i_entry.ppn, i_va[11:0]};
      end
    endcase
    o_hit = i_entry.valid && w_tag_eq;
    o_pa  = o_hit ? w_pa : '0;
  end

  // Permission bits and the VA bits above the translated range are not part
  // of the compare.
  logic w_unused;
  assign w_unused = &{1'b0, i_entry.dirty, i_entry.readable, i_entry.writable,
                      i_entry.executable, i_entry.user, i_entry.gbl, i_va[63:39]};

endmodule

// File: rtl/l1d_tlb.sv
// Fully-associative data-side TLB between the L1D tag pipeline and the
// page-table walker. Hits respond one cycle after acceptance; a miss issues a
// single walk and responds one cycle after the walker returns.
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   clear_tlb                    : invalidate all entries
//   req_valid/req_va/req_ready   : lookup request channel
//   rsp_valid/rsp_pa/rsp_fault,
//   rsp_dirty/read/write/exec/user : registered lookup response
//   walk_req/walk_va             : walk request to walker (l1d_req/l1d_va)
//   walk_gnt                     : walker grant, informational only
//   walk_rsp_valid/walk_rsp      : walker result
module l1d_tlb
  import l1d_tlb_pkg::*;
#(
  parameter int unsigned N_ENTRIES = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clear_tlb,
  input  logic           req_valid,
  input  logic [63:0]    req_va,
  output logic           req_ready,
  output logic           rsp_valid,
  output logic [63:0]    rsp_pa,
  output logic           rsp_fault,
  output logic           rsp_dirty,
  output logic           rsp_read,
  output logic           rsp_write,
  output logic           rsp_exec,
  output logic           rsp_user,
  output logic           walk_req,
  output logic [63:0]    walk_va,
  input  logic           walk_gnt,
  input  logic           walk_rsp_valid,
  input  page_walk_rsp_t walk_rsp
);

  localparam int unsigned IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

  tlb_state_e       r_state;
  tlb_state_e       w_state_nxt;
  tlb_entry_t       r_entries [N_ENTRIES];
  logic [IDX_W-1:0] r_rr_ptr;
  logic             r_clr_pend;

  logic             r_req_ready;
  logic             r_rsp_valid;
  logic [63:0]      r_rsp_pa;
  logic             r_rsp_fault;
  logic [4:0]       r_rsp_flags;   // {dirty, read, write, exec, user}
  logic             r_walk_req;
  logic [63:0]      r_walk_va;

  // ---------------------------------------------------------------- lookup
  logic [N_ENTRIES-1:0] w_hit_vec;
  logic [63:0]          w_pa_vec [N_ENTRIES];
  logic                 w_any_hit;
  logic [63:0]          w_hit_pa;
  logic [4:0]           w_hit_flags;

  for (genvar g = 0; g < N_ENTRIES; g++) begin : g_match
    tlb_match u_match (
      .i_entry (r_entries[g]),
      .i_va    (req_va),
      .o_hit   (w_hit_vec[g]),
      .o_pa    (w_pa_vec[g])
    );
  end

  // At most one entry can match, so a plain OR merges the one-hot results.
  always_comb begin
    w_hit_pa    = '0;
    w_hit_flags = '0;
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      w_hit_pa = w_hit_pa | w_pa_vec[i];
      if (w_hit_vec[i]) begin
        w_hit_flags = w_hit_flags | {r_entries[i].dirty, r_entries[i].readable,
                                     r_entries[i].writable, r_entries[i].executable,
                                     r_entries[i].user};
      end
    end
    w_any_hit = |w_hit_vec;
  end

  // ---------------------------------------------------------------- victim
  logic             w_has_free;
  logic [IDX_W-1:0] w_free_idx;
  logic [IDX_W-1:0] w_victim;
  tlb_entry_t       w_fill_entry;

  always_comb begin
    w_has_free = 1'b0;
    w_free_idx = '0;
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      if (!r_entries[i].valid && !w_has_free) begin
        w_has_free = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
    w_victim = w_has_free ? w_free_idx : r_rr_ptr;

    w_fill_entry            = '0;
    w_fill_entry.valid      = 1'b1;
    w_fill_entry.vpn        = r_walk_va[38:12];
    w_fill_entry.pgsize     = walk_rsp.pgsize;
    w_fill_entry.ppn        = walk_rsp.paddr[55:12];
    w_fill_entry.dirty      = walk_rsp.dirty;
    w_fill_entry.readable   = walk_rsp.readable;
    w_fill_entry.writable   = walk_rsp.writable;
    w_fill_entry.executable = walk_rsp.executable;
    w_fill_entry.user       = walk_rsp.user;
    w_fill_entry.gbl        = walk_rsp.gbl;
  end

  // ------------------------------------------------------------------- FSM
  logic w_accept;
  logic w_lookup_hit;
  logic w_walk_done;
  logic w_fill;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_lookup_hit = 1'b0;
    w_walk_done  = 1'b0;
    w_fill       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          // A clear on the same edge wins over any hit.
          if (w_any_hit && !clear_tlb) w_lookup_hit = 1'b1;
          else                         w_state_nxt  = ST_WALK;
        end
      end
      ST_WALK: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (walk_rsp_valid) begin
          w_walk_done = 1'b1;
          w_fill      = !walk_rsp.fault && !clear_tlb && !r_clr_pend;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_pa    <= '0;
      r_rsp_fault <= 1'b0;
      r_rsp_flags <= '0;
      r_walk_req  <= 1'b0;
      r_walk_va   <= '0;
      r_clr_pend  <= 1'b0;
      r_rr_ptr    <= '0;
      for (int unsigned i = 0; i < N_ENTRIES; i++) r_entries[i] <= '0;
    end else begin
      r_req_ready <= (w_state_nxt == ST_IDLE);
      r_rsp_valid <= w_lookup_hit || w_walk_done;
      r_walk_req  <= w_accept && !w_lookup_hit;

      if (w_lookup_hit) begin
        r_rsp_pa    <= w_hit_pa;
        r_rsp_fault <= 1'b0;
        r_rsp_flags <= w_hit_flags;
      end else if (w_walk_done) begin
        r_rsp_fault <= walk_rsp.fault;
        r_rsp_pa    <= walk_rsp.fault ? '0 : walk_rsp.paddr;
        r_rsp_flags <= walk_rsp.fault ? '0 :
                       {walk_rsp.dirty, walk_rsp.readable, walk_rsp.writable,
                        walk_rsp.executable, walk_rsp.user};
      end

      if (w_accept && !w_lookup_hit) r_walk_va <= req_va;

      // Remember a clear seen while a walk is outstanding so its fill is dropped.
      if (r_state == ST_IDLE) r_clr_pend <= 1'b0;
      else if (clear_tlb)     r_clr_pend <= 1'b1;

      if (clear_tlb) begin
        for (int unsigned i = 0; i < N_ENTRIES; i++) r_entries[i].valid <= 1'b0;
        r_rr_ptr <= '0;
      end else if (w_fill) begin
        r_entries[w_victim] <= w_fill_entry;
        if (!w_has_free) r_rr_ptr <= r_rr_ptr + IDX_W'(1);
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_pa    = r_rsp_pa;
  assign rsp_fault = r_rsp_fault;
  assign rsp_dirty = r_rsp_flags[4];
  assign rsp_read  = r_rsp_flags[3];
  assign rsp_write = r_rsp_flags[2];
  assign rsp_exec  = r_rsp_flags[1];
  assign rsp_user  = r_rsp_flags[0];
  assign walk_req  = r_walk_req;
  assign walk_va   = r_walk_va;

  logic w_unused;
  assign w_unused = &{1'b0, walk_gnt};

endmodule
